// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator to a word-addressed data memory; sub-word stores are read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to make misaligned halfword/word requests return an error instead of being force-aligned.
module lsu_mem_master #(
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned IDX_W     = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic             mem_read,
  output logic             mem_write,
  output logic [IDX_W-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state, state_nxt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [31:0] rdata_q;
  logic [31:0] merged_q;
  logic        rsp_valid_q;

  logic        req_illegal;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_data;
  logic [31:0] merge_word;

  always_comb begin
    req_illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_illegal = 1'b0;
      default:                                req_illegal = 1'b1;
    endcase
    if (req_we && req_funct3[2])
      req_illegal = 1'b1;
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))
      req_illegal = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01 && req_addr[0])
      req_illegal = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00)
      req_illegal = 1'b1;
`endif
  end

  // Without the trap, halfwords look only at addr[1] and words ignore addr[1:0],
  // so the lane selects below already implement forced alignment.
  always_comb begin
    lane_b = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0: lane_b = mem_rdata[7:0];
      2'd1: lane_b = mem_rdata[15:8];
      2'd2: lane_b = mem_rdata[23:16];
      2'd3: lane_b = mem_rdata[31:24];
      default: lane_b = mem_rdata[7:0];
    endcase
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (f3_q)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b100:  load_data = {24'h000000, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b101:  load_data = {16'h0000, lane_h};
      default: load_data = mem_rdata;
    endcase

    merge_word = mem_rdata;
    if (f3_q[0]) begin
      if (addr_q[1]) merge_word[31:16] = wdata_q[15:0];
      else           merge_word[15:0]  = wdata_q[15:0];
    end else begin
      case (addr_q[1:0])
        2'd0: merge_word[7:0]   = wdata_q[7:0];
        2'd1: merge_word[15:8]  = wdata_q[7:0];
        2'd2: merge_word[23:16] = wdata_q[7:0];
        2'd3: merge_word[31:24] = wdata_q[7:0];
        default: merge_word[7:0] = wdata_q[7:0];
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nxt = req_illegal ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_addr = addr_q[IDX_W+1:2];
        if (we_q && f3_q[1:0] == 2'b10) begin
          mem_write = 1'b1;
          mem_wdata = wdata_q;
          state_nxt = RESP;
        end else if (we_q) begin
          mem_read  = 1'b1;
          state_nxt = WRITE;
        end else begin
          mem_read  = 1'b1;
          state_nxt = RESP;
        end
      end
      WRITE: begin
        mem_addr  = addr_q[IDX_W+1:2];
        mem_write = 1'b1;
        mem_wdata = merged_q;
        state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      f3_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      merged_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state       <= state_nxt;
      rsp_valid_q <= (state_nxt == RESP);
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_addr;
          wdata_q <= req_wdata;
          err_q   <= req_illegal;
          rdata_q <= '0;
        end
        ACCESS: begin
          if (!we_q) rdata_q <= load_data;
          merged_q <= merge_word;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_valid_q & err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master with a 64-word combinational-read memory model.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [64];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  lsu_mem_master #(.MEM_WORDS(64), .IDX_W(30)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = (mem_addr < 30'd64) ? mem[mem_addr[5:0]] : 32'hDEAD_BEEF;

  always @(posedge clk)
    if (mem_write && mem_addr < 30'd64) mem[mem_addr[5:0]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Issue one request and watch up to 8 cycles after the accept edge.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                        input logic exp_rd, input logic exp_wr, input logic [31:0] exp_wword);
    int lat = 0;
    logic rd_seen = 1'b0, wr_seen = 1'b0;
    logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0, rdata = '0;
    logic err = 1'b0;
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    check({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_read)  begin rd_seen = 1'b1; rd_addr = {2'b00, mem_addr}; end
      if (mem_write) begin wr_seen = 1'b1; wr_addr = {2'b00, mem_addr}; wr_data = mem_wdata; end
      if (rsp_valid) begin lat = c; rdata = rsp_rdata; err = rsp_err; break; end
    end
    check({tag, "_lat"},   lat, exp_lat);
    check({tag, "_rdata"}, rdata, exp_rdata);
    check({tag, "_err"},   {31'b0, err}, {31'b0, exp_err});
    check({tag, "_rd"},    {31'b0, rd_seen}, {31'b0, exp_rd});
    check({tag, "_wr"},    {31'b0, wr_seen}, {31'b0, exp_wr});
    if (exp_rd) check({tag, "_rdaddr"}, rd_addr, {2'b00, addr[31:2]});
    if (exp_wr) begin
      check({tag, "_wraddr"}, wr_addr, {2'b00, addr[31:2]});
      check({tag, "_wrdata"}, wr_data, exp_wword);
    end
    @(negedge clk);
    check({tag, "_pulse"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[15] = 32'h0000_0041;
    mem[17] = 32'h0000_80F0;
    mem[27] = 32'h1122_3344;
    mem[63] = 32'hCAFE_F00D;

    #1;
    check("rst_ready",  {31'b0, req_ready}, 32'd1);
    check("rst_rsp",    {30'b0, rsp_valid, rsp_err}, 32'd0);
    check("rst_strobe", {30'b0, mem_read, mem_write}, 32'd0);
    check("rst_rdata",  rsp_rdata, 32'd0);
    check("rst_maddr",  {2'b00, mem_addr}, 32'd0);
    check("rst_mwdata", mem_wdata, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_req("lw15",  1'b0, 3'b010, 32'h3C, 32'h0, 2, 32'h0000_0041, 1'b0, 1'b1, 1'b0, 32'h0);
    do_req("sb15",  1'b1, 3'b000, 32'h3D, 32'h1234_56AB, 3, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_AB41);
    check("sb15_mem", mem[15], 32'h0000_AB41);
    do_req("lb45",  1'b0, 3'b000, 32'h45, 32'h0, 2, 32'hFFFF_FF80, 1'b0, 1'b1, 1'b0, 32'h0);
    do_req("lbu45", 1'b0, 3'b100, 32'h45, 32'h0, 2, 32'h0000_0080, 1'b0, 1'b1, 1'b0, 32'h0);
    do_req("lh44",  1'b0, 3'b001, 32'h44, 32'h0, 2, 32'hFFFF_80F0, 1'b0, 1'b1, 1'b0, 32'h0);
    do_req("lhu44", 1'b0, 3'b101, 32'h44, 32'h0, 2, 32'h0000_80F0, 1'b0, 1'b1, 1'b0, 32'h0);
    do_req("lb44",  1'b0, 3'b000, 32'h44, 32'h0, 2, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0, 32'h0);
    do_req("sh46",  1'b1, 3'b001, 32'h46, 32'h0000_CAFE, 3, 32'h0, 1'b0, 1'b1, 1'b1, 32'hCAFE_80F0);
    check("sh46_mem", mem[17], 32'hCAFE_80F0);
    do_req("lhu46", 1'b0, 3'b101, 32'h46, 32'h0, 2, 32'h0000_CAFE, 1'b0, 1'b1, 1'b0, 32'h0);
    do_req("sb47",  1'b1, 3'b000, 32'h47, 32'h0000_0012, 3, 32'h0, 1'b0, 1'b1, 1'b1, 32'h12FE_80F0);
    do_req("sw20",  1'b1, 3'b010, 32'h50, 32'hA5A5_5A5A, 2, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA5A5_5A5A);
    check("sw20_mem", mem[20], 32'hA5A5_5A5A);
    do_req("lw63",  1'b0, 3'b010, 32'hFC, 32'h0, 2, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b0, 32'h0);
    do_req("lw64",  1'b0, 3'b010, 32'h100, 32'h0, 1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    do_req("swf4",  1'b1, 3'b100, 32'h3C, 32'hFFFF_FFFF, 1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    do_req("lf3",   1'b0, 3'b011, 32'h3C, 32'h0, 1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    check("swf4_mem", mem[15], 32'h0000_AB41);
`ifdef LSU_MISALIGN_TRAP_EN
    do_req("lw3e",  1'b0, 3'b010, 32'h3E, 32'h0, 1, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
`else
    do_req("lw3e",  1'b0, 3'b010, 32'h3E, 32'h0, 2, 32'h0000_AB41, 1'b0, 1'b1, 1'b0, 32'h0);
`endif

    // SH to word 27 with reset asserted while the merged write is on the bus.
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h6C; req_wdata = 32'h0000_BEEF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rsh_access_rd", {31'b0, mem_read}, 32'd1);
    @(negedge clk);
    check("rsh_write_wr",  {31'b0, mem_write}, 32'd1);
    check("rsh_write_dat", mem_wdata, 32'h1122_BEEF);
    rst = 1'b1;
    #1;
    check("rsh_rst_wr",    {31'b0, mem_write}, 32'd0);
    check("rsh_rst_maddr", {2'b00, mem_addr}, 32'd0);
    check("rsh_rst_mwdat", mem_wdata, 32'd0);
    check("rsh_rst_rsp",   {30'b0, rsp_valid, rsp_err}, 32'd0);
    check("rsh_rst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    begin
      logic any_act = 1'b0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (mem_write || mem_read || rsp_valid) any_act = 1'b1;
      end
      check("rsh_quiet", {31'b0, any_act}, 32'd0);
    end
    check("rsh_mem27", mem[27], 32'h1122_3344);
    check("rsh_ready", {31'b0, req_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
